// File: rtl/reaction_meter_if.sv
// Player-side signal bundle of the reaction meter: trial control and stimulus in,
// measurement results out.
interface reaction_meter_if #(
  parameter int W = 12
);
  logic         arm;
  logic         stim;
  logic         press;
  logic [W-1:0] rt_ms;
  logic         valid;
  logic         early;
  logic         timeout;
  logic         busy;
  logic [W-1:0] best_ms;

  modport master (
    output arm, stim, press,
    input  rt_ms, valid, early, timeout, busy, best_ms
  );

  modport slave (
    input  arm, stim, press,
    output rt_ms, valid, early, timeout, busy, best_ms
  );
endinterface

// File: rtl/reaction_meter.sv
// Measures the time in ms from the stimulus light rising to a synchronized button press,
// flags false starts and timeouts, and tracks the best valid time since reset.
module reaction_meter #(
  parameter int W      = 12,
  parameter int MAX_MS = 2000
) (
  input  logic                clk1k,
  input  logic                rst_n,
  reaction_meter_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_STIM = 3'd1,
    S_MEASURE   = 3'd2,
    S_DONE      = 3'd3,
    S_EARLY     = 3'd4,
    S_TIMEOUT   = 3'd5
  } state_t;

  localparam logic [W-1:0] MAX_CNT = W'(MAX_MS);

  state_t       state_q,   state_d;
  logic [W-1:0] cnt_q,     cnt_d;
  logic [W-1:0] rt_q,      rt_d;
  logic [W-1:0] best_q,    best_d;
  logic         valid_q,   valid_d;
  logic         early_q,   early_d;
  logic         timeout_q, timeout_d;
  logic         busy_q,    busy_d;
  logic [2:0]   sync_q,    sync_d;
  logic         press_edge_s;

  // sync_q[0]/[1] are the metastability pair, sync_q[2] delays s2 for edge detection
  assign sync_d       = {sync_q[1:0], bus.press};
  assign press_edge_s = sync_q[1] & ~sync_q[2];

  // Next-state and next-output logic for the trial FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rt_d      = rt_q;
    best_d    = best_q;
    valid_d   = valid_q;
    early_d   = early_q;
    timeout_d = timeout_q;
    if (bus.arm) begin
      state_d   = S_WAIT_STIM;
      cnt_d     = '0;
      rt_d      = '0;
      valid_d   = 1'b0;
      early_d   = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_STIM: begin
          if (press_edge_s) begin
            state_d = S_EARLY;
            early_d = 1'b1;
          end else if (bus.stim) begin
            state_d = S_MEASURE;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT_STIM;
          end
        end
        S_MEASURE: begin
          if (press_edge_s) begin
            state_d = S_DONE;
            rt_d    = cnt_q;
            valid_d = 1'b1;
            if (cnt_q < best_q) begin
              best_d = cnt_q;
            end else begin
              best_d = best_q;
            end
          end else if (cnt_q == MAX_CNT) begin
            state_d   = S_TIMEOUT;
            rt_d      = MAX_CNT;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    busy_d = (state_d == S_WAIT_STIM) || (state_d == S_MEASURE);
  end

  // State, result and synchronizer registers
  always_ff @(posedge clk1k or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rt_q      <= '0;
      best_q    <= '1;
      valid_q   <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      sync_q    <= 3'b000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rt_q      <= rt_d;
      best_q    <= best_d;
      valid_q   <= valid_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      sync_q    <= sync_d;
    end
  end

  assign bus.rt_ms   = rt_q;
  assign bus.best_ms = best_q;
  assign bus.valid   = valid_q;
  assign bus.early   = early_q;
  assign bus.timeout = timeout_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_reaction_meter.sv
// Randomized bench for reaction_meter: a trial-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_reaction_meter;
  localparam int W      = 12;
  localparam int MAX_MS = 2000;

  logic clk1k = 1'b0;
  logic rst_n = 1'b0;

  reaction_meter_if #(.W(W)) bus ();

  reaction_meter #(.W(W), .MAX_MS(MAX_MS)) dut (
    .clk1k (clk1k),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk1k = ~clk1k;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase 0 idle, 1 waiting for light, 2 measuring, 3 finished
  int m_phase   = 0;
  int m_edge    = 0;
  int m_entry   = 0;
  int m_rt      = 0;
  int m_best    = (1 << W) - 1;
  bit m_valid   = 1'b0;
  bit m_early   = 1'b0;
  bit m_timeout = 1'b0;
  bit m_hist[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
  endtask

  // press level sampled k edges ago (1 = most recent); nothing sampled yet reads as 0
  function automatic bit past(int k);
    if (m_hist.size() >= k) return m_hist[m_hist.size() - k];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_rt = 0; m_best = (1 << W) - 1;
    m_valid = 1'b0; m_early = 1'b0; m_timeout = 1'b0;
    m_hist.delete();
  endtask

  task automatic model_step(bit arm, bit stim, bit press);
    bit pe;
    int elapsed;
    pe      = past(2) && !past(3);
    elapsed = m_edge - m_entry - 1;
    if (arm) begin
      m_phase = 1; m_rt = 0;
      m_valid = 1'b0; m_early = 1'b0; m_timeout = 1'b0;
    end else if (m_phase == 1) begin
      if (pe) begin
        m_phase = 3; m_early = 1'b1;
      end else if (stim) begin
        m_phase = 2; m_entry = m_edge;
      end
    end else if (m_phase == 2) begin
      if (pe) begin
        m_phase = 3; m_rt = elapsed; m_valid = 1'b1;
        if (elapsed < m_best) m_best = elapsed;
      end else if (elapsed == MAX_MS) begin
        m_phase = 3; m_rt = MAX_MS; m_timeout = 1'b1;
      end
    end
    m_hist.push_back(press);
    if (m_hist.size() > 3) void'(m_hist.pop_front());
    m_edge++;
  endtask

  initial begin
    forever begin
      @(posedge clk1k or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(bus.arm, bus.stim, bus.press);
    end
  end

  initial begin
    forever begin
      @(negedge clk1k);
      chk("cyc_rt_ms",   bus.rt_ms,   m_rt);
      chk("cyc_best_ms", bus.best_ms, m_best);
      chk("cyc_valid",   bus.valid,   m_valid);
      chk("cyc_early",   bus.early,   m_early);
      chk("cyc_timeout", bus.timeout, m_timeout);
      chk("cyc_busy",    bus.busy,    (m_phase == 1 || m_phase == 2));
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk1k);
    #1;
  endtask

  task automatic do_arm();
    bus.stim  = 1'b0;
    bus.press = 1'b0;
    bus.arm   = 1'b1;
    tick(1);
    bus.arm   = 1'b0;
  endtask

  // press is raised pdelay cycles after the MEASURE entry edge
  task automatic trial(int gap, int pdelay, bit drop_stim);
    do_arm();
    tick(gap);
    bus.stim = 1'b1;
    tick(1);
    if (drop_stim) begin
      tick(pdelay / 2);
      bus.stim = 1'b0;
      tick(pdelay - pdelay / 2);
    end else begin
      tick(pdelay);
    end
    bus.press = 1'b1;
    tick(4);
  endtask

  initial begin
    bus.arm = 1'b0; bus.stim = 1'b0; bus.press = 1'b0;
    #23 rst_n = 1'b1;
    tick(2);
    chk("reset_best", bus.best_ms, 32'd4095);
    chk("reset_busy", bus.busy, 32'd0);

    // T1
    trial(10, 250, 1'b0);
    chk("t1_rt", bus.rt_ms, 32'd252);
    chk("t1_valid", bus.valid, 32'd1);
    chk("t1_best", bus.best_ms, 32'd252);
    chk("t1_busy", bus.busy, 32'd0);

    // T2
    trial(10, 400, 1'b0);
    chk("t2_rt", bus.rt_ms, 32'd402);
    chk("t2_best_kept", bus.best_ms, 32'd252);
    trial(7, 100, 1'b0);
    chk("t2_best_new", bus.best_ms, 32'd102);

    // T3: false start, later stim ignored
    do_arm();
    tick(5);
    bus.press = 1'b1;
    tick(4);
    chk("t3_early", bus.early, 32'd1);
    chk("t3_valid", bus.valid, 32'd0);
    chk("t3_rt", bus.rt_ms, 32'd0);
    bus.stim = 1'b1;
    tick(5);
    chk("t3_early_hold", bus.early, 32'd1);
    chk("t3_busy", bus.busy, 32'd0);
    chk("t3_best", bus.best_ms, 32'd102);

    // T4: timeout lands exactly MAX_MS+1 edges after entry
    do_arm();
    tick(3);
    bus.stim = 1'b1;
    tick(1);
    tick(MAX_MS);
    chk("t4_not_yet", bus.timeout, 32'd0);
    chk("t4_busy_before", bus.busy, 32'd1);
    tick(1);
    chk("t4_timeout", bus.timeout, 32'd1);
    chk("t4_rt", bus.rt_ms, 32'd2000);
    chk("t4_busy_after", bus.busy, 32'd0);

    // T5a: arm beats press_edge in MEASURE
    do_arm();
    tick(3);
    bus.stim = 1'b1;
    tick(21);
    bus.press = 1'b1;
    tick(2);
    bus.arm = 1'b1;
    tick(1);
    bus.arm = 1'b0;
    chk("t5_busy", bus.busy, 32'd1);
    chk("t5_valid", bus.valid, 32'd0);
    chk("t5_rt", bus.rt_ms, 32'd0);

    // T5b: press_edge and stim together in WAIT_STIM
    do_arm();
    tick(4);
    bus.press = 1'b1;
    tick(2);
    bus.stim = 1'b1;
    tick(1);
    chk("t5_early", bus.early, 32'd1);
    chk("t5_early_busy", bus.busy, 32'd0);

    // T6: asynchronous reset mid-MEASURE
    do_arm();
    tick(3);
    bus.stim = 1'b1;
    tick(50);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rt", bus.rt_ms, 32'd0);
    chk("t6_valid", bus.valid, 32'd0);
    chk("t6_timeout", bus.timeout, 32'd0);
    chk("t6_busy", bus.busy, 32'd0);
    chk("t6_best", bus.best_ms, 32'd4095);
    tick(1);
    #2 rst_n = 1'b1;
    bus.stim = 1'b0; bus.press = 1'b0;
    tick(2);
    trial(5, 30, 1'b0);
    chk("t6_rearm_rt", bus.rt_ms, 32'd32);
    chk("t6_rearm_best", bus.best_ms, 32'd32);

    // Randomized trials, checked against the model every cycle
    for (int i = 0; i < 25; i++) begin
      int mode;
      mode = $urandom_range(0, 3);
      if (mode < 3) begin
        trial($urandom_range(1, 15), $urandom_range(0, 300), mode == 2);
      end else begin
        do_arm();
        tick($urandom_range(1, 12));
        bus.press = 1'b1;
        tick($urandom_range(0, 3));
        bus.stim = $urandom_range(0, 1);
        tick($urandom_range(1, 8));
      end
    end

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
